// File: rtl/rf_scoreboard.sv
// Multi-read-port register file with write-through bypass and a per-register
// pending-writer scoreboard for the ID stage. Register 0 reads as zero.
module rf_scoreboard #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NRP    = 2,
    parameter int BYPASS = 1,
    parameter int CW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRP*AW-1:0] rR,
    output logic [NRP*DW-1:0] RD,
    output logic [NRP-1:0]    rd_pend,
    input  logic [AW-1:0]     WR,
    input  logic [DW-1:0]     WD,
    input  logic              rf_we,
    input  logic              iss_we,
    input  logic [AW-1:0]     iss_wr,
    output logic              iss_full,
    output logic              err
);

    localparam int unsigned DEPTH = 2**AW;

    logic [DW-1:0] regs [DEPTH];
    logic [CW-1:0] cnt  [DEPTH];

    logic          wr_ok;
    logic          inc;
    logic          dec;
    logic          iss_bad;
    logic          ret_bad;

    logic [AW-1:0] ra;
    logic [CW-1:0] ra_cnt;
    logic          hit;

    // iss_full deliberately ignores a same-cycle retire: no path from rf_we.
    assign iss_full = (iss_wr != '0) && (cnt[iss_wr] == '1);
    assign wr_ok    = rf_we && (WR != '0);
    assign inc      = iss_we && (iss_wr != '0) && !iss_full;
    assign dec      = wr_ok && (cnt[WR] != '0);
    assign iss_bad  = iss_we && iss_full;
    assign ret_bad  = wr_ok && (cnt[WR] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (iss_bad || ret_bad)
                err <= 1'b1;
            if (wr_ok)
                regs[WR] <= WD;
            // An issue and a retire of the same register cancel out.
            if (inc && !(dec && (WR == iss_wr)))
                cnt[iss_wr] <= cnt[iss_wr] + 1'b1;
            if (dec && !(inc && (WR == iss_wr)))
                cnt[WR] <= cnt[WR] - 1'b1;
        end
    end

    always_comb begin
        RD      = '0;
        rd_pend = '0;
        ra      = '0;
        ra_cnt  = '0;
        hit     = 1'b0;
        for (int unsigned i = 0; i < NRP; i++) begin
            ra     = rR[i*AW +: AW];
            ra_cnt = cnt[ra];
            hit    = (BYPASS != 0) && !rst && rf_we && (WR == ra) && (ra != '0);
            if (ra == '0)
                RD[i*DW +: DW] = '0;
            else if (hit)
                RD[i*DW +: DW] = WD;
            else
                RD[i*DW +: DW] = regs[ra];
            // With bypass, a retiring writer already delivers its data this cycle.
            rd_pend[i] = (ra != '0) && (ra_cnt != '0) && !(hit && (ra_cnt == CW'(1)));
        end
    end

endmodule
